spi1_wb_bridge: RTL and testbench

Synthesizable SPI1 command decoder: consumes the byte stream from the SPI1 target deserializer and issues Wishbone master cycles into the PET bus fabric. It is the parametrised successor of the original fixed 8-bit/20-bit SPI1 command path. It adds configurable data and address widths, multi-word bursts within one chip-select frame, and an explicit overrun indication. The block sits between the SPI1 target shifter (`rx_*`, `tx_data_o`) and the Wishbone interconnect.

---
 rtl/spi1_wb_pkg.sv | 21 ++
 rtl/spi1_byte_assembler.sv | 33 +++
 rtl/spi1_wb_bridge.sv | 163 ++++++++++++++++
 tb/tb_spi1_wb_bridge.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi1_wb_pkg.sv
// Shared types and helpers for the SPI1 command decoder / Wishbone bridge.
package spi1_wb_pkg;

    typedef enum logic [2:0] {
        ST_CMD  = 3'd0,
        ST_ADDR = 3'd1,
        ST_DATA = 3'd2,
        ST_REQ  = 3'd3,
        ST_WAIT = 3'd4
    } spi1_wb_state_t;

    localparam int unsigned CMD_WE_BIT       = 7;
    localparam int unsigned CMD_SET_ADDR_BIT = 6;

    // Number of address bytes that follow a set_addr command: the command
    // nibble supplies the top 4 bits, the bytes supply the rest.
    function automatic int unsigned addr_bytes(input int unsigned width);
        return (width - 4 + 7) / 8;
    endfunction

endpackage

// File: rtl/spi1_byte_assembler.sv
// Shifts received bytes MSB-first into a WIDTH-bit word and counts them.
// word_next_o is the word including the byte currently being shifted, so the
// consumer can capture a completed group in the same cycle as its last byte.
module spi1_byte_assembler #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             clear_i,
    input  logic             shift_i,
    input  logic [7:0]       byte_i,
    output logic [WIDTH-1:0] word_next_o,
    output logic [2:0]       count_o
);

    logic [WIDTH-1:0] word_q;
    logic [WIDTH+7:0] word_ext;

    assign word_ext    = {word_q, byte_i};
    assign word_next_o = word_ext[WIDTH-1:0];

    // Clear has priority so a completed group leaves the assembler empty.
    always_ff @(posedge clock_i) begin
        if (reset_i || clear_i) begin
            word_q  <= '0;
            count_o <= '0;
        end else if (shift_i) begin
            word_q  <= word_next_o;
            count_o <= count_o + 3'd1;
        end
    end

endmodule

// File: rtl/spi1_wb_bridge.sv
// SPI1 command decoder issuing Wishbone pipelined master cycles.
// Optional feature macro: SPI1_WB_ADDR_AUTOINC_EN (address increments after
// every acked cycle; when undefined the held address stays constant).
module spi1_wb_bridge #(
    parameter int unsigned WB_DATA_WIDTH = 8,
    parameter int unsigned WB_ADDR_WIDTH = 20
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic                     cs_active_i,
    input  logic                     rx_valid_i,
    input  logic [7:0]               rx_data_i,
    output logic [WB_DATA_WIDTH-1:0] tx_data_o,
    output logic                     stall_o,
    output logic                     overrun_o,
    output logic                     wb_cyc_o,
    output logic                     wb_stb_o,
    output logic                     wb_we_o,
    output logic [WB_ADDR_WIDTH-1:0] wb_addr_o,
    output logic [WB_DATA_WIDTH-1:0] wb_data_o,
    input  logic [WB_DATA_WIDTH-1:0] wb_data_i,
    input  logic                     wb_ack_i,
    input  logic                     wb_stall_i
);
    import spi1_wb_pkg::*;

    localparam int unsigned DATA_BYTES = WB_DATA_WIDTH / 8;
    localparam int unsigned ADDR_BYTES = addr_bytes(WB_ADDR_WIDTH);
    localparam int unsigned LOW_W      = ADDR_BYTES * 8;
    localparam int unsigned ASM_W      = (LOW_W > WB_DATA_WIDTH) ? LOW_W : WB_DATA_WIDTH;
    localparam logic [2:0]  ADDR_LAST  = 3'(ADDR_BYTES - 1);
    localparam logic [2:0]  DATA_LAST  = 3'(DATA_BYTES - 1);

    spi1_wb_state_t           state_q;
    logic [WB_ADDR_WIDTH-1:0] addr_q;
    logic [WB_DATA_WIDTH-1:0] wr_data_q;
    logic [WB_DATA_WIDTH-1:0] tx_q;
    logic [3:0]               nib_q;
    logic                     we_q;
    logic                     cs_lost_q;
    logic                     overrun_q;

    logic                     busy;
    logic                     accept;
    logic                     addr_done;
    logic                     data_done;
    logic                     ack_done;
    logic                     asm_clear;
    logic                     asm_shift;
    logic [ASM_W-1:0]         asm_next;
    logic [2:0]               asm_count;
    logic [LOW_W+3:0]         full_addr;
    logic                     unused_bits;

    assign busy      = (state_q == ST_REQ) || (state_q == ST_WAIT);
    assign accept    = rx_valid_i && cs_active_i && !busy;
    assign addr_done = accept && (state_q == ST_ADDR) && (asm_count == ADDR_LAST);
    assign data_done = accept && (state_q == ST_DATA) && (asm_count == DATA_LAST);
    // A zero-wait slave may ack in the same cycle the request is accepted.
    assign ack_done  = wb_ack_i && ((state_q == ST_WAIT) ||
                                    (state_q == ST_REQ && !wb_stall_i));
    assign asm_clear = (state_q == ST_CMD) || !cs_active_i || addr_done || data_done;
    assign asm_shift = accept && ((state_q == ST_ADDR) || (state_q == ST_DATA));
    // Command nibble bits above the address width fall off when truncated.
    assign full_addr = {nib_q, asm_next[LOW_W-1:0]};
    assign unused_bits = ^{rx_data_i[5:4], full_addr};

    spi1_byte_assembler #(
        .WIDTH (ASM_W)
    ) u_asm (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .clear_i     (asm_clear),
        .shift_i     (asm_shift),
        .byte_i      (rx_data_i),
        .word_next_o (asm_next),
        .count_o     (asm_count)
    );

    // Command decode, byte grouping and Wishbone cycle sequencing.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= ST_CMD;
            addr_q    <= '0;
            wr_data_q <= '0;
            tx_q      <= '0;
            nib_q     <= '0;
            we_q      <= 1'b0;
            cs_lost_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= rx_valid_i && busy;
            if (ack_done) begin
`ifdef SPI1_WB_ADDR_AUTOINC_EN
                addr_q <= addr_q + {{(WB_ADDR_WIDTH-1){1'b0}}, 1'b1};
`endif
                if (!we_q) begin
                    tx_q <= wb_data_i;
                end
                state_q <= (cs_lost_q || !cs_active_i) ? ST_CMD : ST_DATA;
            end else begin
                case (state_q)
                    ST_CMD: begin
                        cs_lost_q <= 1'b0;
                        if (accept) begin
                            we_q <= rx_data_i[CMD_WE_BIT];
                            if (rx_data_i[CMD_SET_ADDR_BIT]) begin
                                nib_q   <= rx_data_i[3:0];
                                state_q <= ST_ADDR;
                            end else if (rx_data_i[CMD_WE_BIT]) begin
                                state_q <= ST_DATA;
                            end else begin
                                state_q <= ST_REQ;
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (!cs_active_i) begin
                            state_q <= ST_CMD;
                        end else if (addr_done) begin
                            addr_q  <= full_addr[WB_ADDR_WIDTH-1:0];
                            state_q <= we_q ? ST_DATA : ST_REQ;
                        end
                    end
                    ST_DATA: begin
                        if (!cs_active_i) begin
                            state_q <= ST_CMD;
                        end else if (data_done) begin
                            if (we_q) begin
                                wr_data_q <= asm_next[WB_DATA_WIDTH-1:0];
                            end
                            state_q <= ST_REQ;
                        end
                    end
                    ST_REQ: begin
                        if (!cs_active_i) begin
                            cs_lost_q <= 1'b1;
                        end
                        if (!wb_stall_i) begin
                            state_q <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (!cs_active_i) begin
                            cs_lost_q <= 1'b1;
                        end
                    end
                    default: state_q <= ST_CMD;
                endcase
            end
        end
    end

    assign stall_o   = busy;
    assign overrun_o = overrun_q;
    assign wb_cyc_o  = busy;
    assign wb_stb_o  = (state_q == ST_REQ);
    assign wb_we_o   = busy && we_q;
    assign wb_addr_o = addr_q;
    assign wb_data_o = wr_data_q;
    assign tx_data_o = tx_q;

endmodule

// File: tb/tb_spi1_wb_bridge.sv
// Self-checking bench for spi1_wb_bridge: frame table on an 8/20 instance,
// hand sequences for timing, stall/overrun, reset-in-WAIT and a 16-bit burst.
module tb_spi1_wb_bridge;

`ifdef SPI1_WB_ADDR_AUTOINC_EN
    localparam bit AI = 1'b1;
`else
    localparam bit AI = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       cs8 = 1'b0, cs16 = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = '0;

    // 8-bit instance signals
    logic [7:0]  tx8, wdat8, rdat8;
    logic [19:0] addr8;
    logic        stall8, ovr8, cyc8, stb8, we8, ack8, sstall8, noack8;
    // 16-bit instance signals
    logic [15:0] tx16, wdat16, rdat16;
    logic [19:0] addr16;
    logic        stall16, ovr16, cyc16, stb16, we16, ack16, sstall16;

    int checks = 0;
    int errors = 0;

    spi1_wb_bridge #(.WB_DATA_WIDTH(8), .WB_ADDR_WIDTH(20)) dut8 (
        .clock_i(clk), .reset_i(rst), .cs_active_i(cs8), .rx_valid_i(rx_valid),
        .rx_data_i(rx_data), .tx_data_o(tx8), .stall_o(stall8), .overrun_o(ovr8),
        .wb_cyc_o(cyc8), .wb_stb_o(stb8), .wb_we_o(we8), .wb_addr_o(addr8),
        .wb_data_o(wdat8), .wb_data_i(rdat8), .wb_ack_i(ack8), .wb_stall_i(sstall8)
    );

    spi1_wb_bridge #(.WB_DATA_WIDTH(16), .WB_ADDR_WIDTH(20)) dut16 (
        .clock_i(clk), .reset_i(rst), .cs_active_i(cs16), .rx_valid_i(rx_valid),
        .rx_data_i(rx_data), .tx_data_o(tx16), .stall_o(stall16), .overrun_o(ovr16),
        .wb_cyc_o(cyc16), .wb_stb_o(stb16), .wb_we_o(we16), .wb_addr_o(addr16),
        .wb_data_o(wdat16), .wb_data_i(rdat16), .wb_ack_i(ack16), .wb_stall_i(sstall16)
    );

    // Slave models: ack one cycle after an accepted strobe, log accepted requests.
    logic [19:0] log8_a [64];
    logic [7:0]  log8_d [64];
    logic        log8_w [64];
    int          log8_n = 0;
    logic [19:0] log16_a [64];
    logic [15:0] log16_d [64];
    int          log16_n = 0;

    always @(posedge clk) begin
        if (rst) ack8 <= 1'b0;
        else     ack8 <= cyc8 && stb8 && !sstall8 && !noack8;
        if (!rst && cyc8 && stb8 && !sstall8) begin
            log8_a[log8_n] <= addr8;
            log8_d[log8_n] <= wdat8;
            log8_w[log8_n] <= we8;
            log8_n <= log8_n + 1;
        end
    end

    always @(posedge clk) begin
        if (rst) ack16 <= 1'b0;
        else     ack16 <= cyc16 && stb16 && !sstall16;
        if (!rst && cyc16 && stb16 && !sstall16) begin
            log16_a[log16_n] <= addr16;
            log16_d[log16_n] <= wdat16;
            log16_n <= log16_n + 1;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; waits (bounded) for the bridge to accept bytes.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        while ((stall8 || stall16) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL send_wait: stall_o stuck high, got 1 expected 0");
        end
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic end_frame();
        int n = 0;
        while ((stall8 || stall16) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL frame_wait: stall_o stuck high, got 1 expected 0");
        end
        cs8  = 1'b0;
        cs16 = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    typedef struct {
        int          nb;
        logic [47:0] bytes;   // MSB-first byte stream
        logic [7:0]  rd;      // slave read data
        int          n;       // expected Wishbone cycles
        logic        we;
        logic [19:0] a0, a1;
        logic [7:0]  d0, d1;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int base, cnt_stall, cnt_stb, cnt_ovr;
        logic [7:0] b;
        vec_t v;

        vecs[0] = '{nb:4, bytes:48'hC3_12_34_5A_00_00, rd:8'h00, n:1, we:1'b1,
                    a0:20'h31234, a1:20'h0, d0:8'h5A, d1:8'h00};
        vecs[1] = '{nb:3, bytes:48'h40_80_00_00_00_00, rd:8'h77, n:1, we:1'b0,
                    a0:20'h08000, a1:20'h0, d0:8'h00, d1:8'h00};
        vecs[2] = '{nb:1, bytes:48'h00_00_00_00_00_00, rd:8'h3C, n:1, we:1'b0,
                    a0:(AI ? 20'h08001 : 20'h08000), a1:20'h0, d0:8'h00, d1:8'h00};
        vecs[3] = '{nb:2, bytes:48'hC3_12_00_00_00_00, rd:8'h00, n:0, we:1'b1,
                    a0:20'h0, a1:20'h0, d0:8'h00, d1:8'h00};
        vecs[4] = '{nb:2, bytes:48'h80_99_00_00_00_00, rd:8'h00, n:1, we:1'b1,
                    a0:(AI ? 20'h08002 : 20'h08000), a1:20'h0, d0:8'h99, d1:8'h00};
        vecs[5] = '{nb:5, bytes:48'hCF_FF_FF_11_22_00, rd:8'h00, n:2, we:1'b1,
                    a0:20'hFFFFF, a1:(AI ? 20'h00000 : 20'hFFFFF), d0:8'h11, d1:8'h22};
        vecs[6] = '{nb:4, bytes:48'h40_00_20_AA_00_00, rd:8'h5E, n:2, we:1'b0,
                    a0:20'h00020, a1:(AI ? 20'h00021 : 20'h00020), d0:8'h00, d1:8'h00};

        sstall8 = 1'b0; noack8 = 1'b0; rdat8 = '0;
        sstall16 = 1'b0; rdat16 = 16'h0000;

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_cyc", {31'd0, cyc8}, 0);
        chk("rst_stb", {31'd0, stb8}, 0);
        chk("rst_we", {31'd0, we8}, 0);
        chk("rst_stall", {31'd0, stall8}, 0);
        chk("rst_overrun", {31'd0, ovr8}, 0);
        chk("rst_tx", {24'd0, tx8}, 0);
        chk("rst_addr", {12'd0, addr8}, 0);
        chk("rst_wdata", {24'd0, wdat8}, 0);
        chk("rst_cyc16", {31'd0, cyc16}, 0);

        // Table-driven frames on the 8-bit instance
        for (int i = 0; i < 7; i++) begin
            v = vecs[i];
            rdat8 = v.rd;
            base = log8_n;
            cs8 = 1'b1;
            @(negedge clk);
            for (int k = 0; k < v.nb; k++) begin
                b = v.bytes[47-8*k -: 8];
                send_byte(b);
            end
            end_frame();
            chk($sformatf("v%0d_count", i), log8_n - base, v.n);
            if (v.n >= 1) begin
                chk($sformatf("v%0d_addr0", i), {12'd0, log8_a[base]}, {12'd0, v.a0});
                chk($sformatf("v%0d_we0", i), {31'd0, log8_w[base]}, {31'd0, v.we});
                if (v.we) chk($sformatf("v%0d_data0", i), {24'd0, log8_d[base]}, {24'd0, v.d0});
            end
            if (v.n >= 2) begin
                chk($sformatf("v%0d_addr1", i), {12'd0, log8_a[base+1]}, {12'd0, v.a1});
                if (v.we) chk($sformatf("v%0d_data1", i), {24'd0, log8_d[base+1]}, {24'd0, v.d1});
            end
            if (!v.we) chk($sformatf("v%0d_tx", i), {24'd0, tx8}, {24'd0, v.rd});
        end

        // Timing with a zero-wait slave: cyc/stb/stall rise in N+1, stall high 2 cycles
        cs8 = 1'b1;
        @(negedge clk);
        send_byte(8'hC3); send_byte(8'h12); send_byte(8'h34); send_byte(8'h5A);
        chk("t_cyc_n1", {31'd0, cyc8}, 1);
        chk("t_stb_n1", {31'd0, stb8}, 1);
        chk("t_stall_n1", {31'd0, stall8}, 1);
        cnt_stall = 0;
        for (int k = 0; k < 6; k++) begin
            if (stall8) cnt_stall++;
            @(negedge clk);
        end
        chk("t_stall_cycles", cnt_stall, 2);
        chk("t_cyc_after", {31'd0, cyc8}, 0);
        chk("t_addr_after", {12'd0, addr8}, AI ? 32'h31235 : 32'h31234);
        end_frame();

        // Slave stall for 3 cycles plus an overrun byte during the stall
        base = log8_n;
        cs8 = 1'b1;
        @(negedge clk);
        send_byte(8'hC3); send_byte(8'h12); send_byte(8'h34);
        sstall8 = 1'b1;
        send_byte(8'h5A);
        cnt_stb = 0;
        cnt_ovr = 0;
        for (int k = 0; k < 10; k++) begin
            if (stb8) cnt_stb++;
            if (ovr8) cnt_ovr++;
            if (cnt_stb == 4) sstall8 = 1'b0;
            if (k == 1) begin rx_valid = 1'b1; rx_data = 8'hEE; end
            if (k == 2) rx_valid = 1'b0;
            @(negedge clk);
        end
        sstall8 = 1'b0;
        end_frame();
        chk("s_stb_cycles", cnt_stb, 4);
        chk("s_overrun_pulses", cnt_ovr, 1);
        chk("s_write_count", log8_n - base, 1);
        chk("s_write_data", {24'd0, log8_d[base]}, 32'h5A);

        // Reset during WAIT: cyc drops next cycle, next frame starts from CMD
        noack8 = 1'b1;
        cs8 = 1'b1;
        @(negedge clk);
        send_byte(8'hC3); send_byte(8'h12); send_byte(8'h34); send_byte(8'h5A);
        @(negedge clk);
        chk("r_wait_cyc", {31'd0, cyc8}, 1);
        chk("r_wait_stb", {31'd0, stb8}, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("r_cyc_low", {31'd0, cyc8}, 0);
        chk("r_stall_low", {31'd0, stall8}, 0);
        chk("r_addr_zero", {12'd0, addr8}, 0);
        rst = 1'b0;
        noack8 = 1'b0;
        cs8 = 1'b0;
        repeat (2) @(negedge clk);
        rdat8 = 8'h42;
        base = log8_n;
        cs8 = 1'b1;
        @(negedge clk);
        send_byte(8'h40); send_byte(8'h00); send_byte(8'h05);
        end_frame();
        chk("r_next_count", log8_n - base, 1);
        chk("r_next_addr", {12'd0, log8_a[base]}, 32'h00005);
        chk("r_next_tx", {24'd0, tx8}, 32'h42);

        // 16-bit burst
        base = log16_n;
        cs16 = 1'b1;
        @(negedge clk);
        send_byte(8'hC0); send_byte(8'h00); send_byte(8'h10);
        send_byte(8'hAB); send_byte(8'hCD); send_byte(8'h12); send_byte(8'h34);
        end_frame();
        chk("b16_count", log16_n - base, 2);
        chk("b16_addr0", {12'd0, log16_a[base]}, 32'h00010);
        chk("b16_data0", {16'd0, log16_d[base]}, 32'hABCD);
        chk("b16_addr1", {12'd0, log16_a[base+1]}, AI ? 32'h00011 : 32'h00010);
        chk("b16_data1", {16'd0, log16_d[base+1]}, 32'h1234);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
